seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier for the multi-cycle datapath, successor to the fixed 32-bit unit. Computes a full 2×WIDTH-bit product over WIDTH iterations, with a start/ready/done handshake and an optional signed mode. The multi-cycle control FSM uses it for MULT/MULTU: it pulses `start` and stalls until `done`.

---
 rtl/mult_pkg.sv | 17 +
 rtl/seq_multiplier_cond_negate.sv | 12 +
 rtl/seq_multiplier.sv | 135 +++++++++++++
 tb/tb_seq_multiplier.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } mult_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_cond_negate.sv
// Conditional two's-complement negator of parametrised width.
module cond_negate #(
  parameter int W = 8
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, 2*WIDTH-bit product in WIDTH+1 cycles.
// Signed operation is synthesised only when MULT_SIGNED_EN is defined.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic               ready,
  output logic               busy,
  output logic               done
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             sign_q, sign_d;
  logic [W2-1:0]    product_q, product_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    res;
  logic             sign_in;

`ifdef MULT_SIGNED_EN
  logic neg_a, neg_b;
  assign neg_a   = is_signed & A[WIDTH-1];
  assign neg_b   = is_signed & B[WIDTH-1];
  assign sign_in = neg_a ^ neg_b;

  cond_negate #(.W(WIDTH)) u_neg_a (
    .neg  (neg_a),
    .din  (A),
    .dout (a_mag)
  );

  cond_negate #(.W(WIDTH)) u_neg_b (
    .neg  (neg_b),
    .din  (B),
    .dout (b_mag)
  );

  cond_negate #(.W(W2)) u_neg_p (
    .neg  (sign_q),
    .din  (acc_q),
    .dout (res)
  );
`else
  logic unused_sign;
  assign unused_sign = is_signed ^ sign_q;
  assign a_mag   = A;
  assign b_mag   = B;
  assign sign_in = 1'b0;
  assign res     = acc_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    sign_d    = sign_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          sign_d   = sign_in;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        product_d = res;
        state_d   = DONE;
      end
    endcase
    ready_d = (state_d == IDLE) || (state_d == DONE);
    done_d  = (state_q == FIX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign Product = product_q;
  assign ready   = ready_q;
  assign busy    = ~ready_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=32 and WIDTH=8 instances).
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, is_signed;
  logic [31:0] a, b;
  logic [63:0] product;
  logic        ready, busy, done;

  logic        start8, is_signed8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        ready8, busy8, done8;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .A(a), .B(b), .Product(product),
    .ready(ready), .busy(busy), .done(done)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(is_signed8),
    .A(a8), .B(b8), .Product(product8),
    .ready(ready8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp_u;
    logic [63:0] exp_s;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication of the operands' values.
  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic s);
    logic use_s;
    longint sx, sy;
`ifdef MULT_SIGNED_EN
    use_s = s;
`else
    use_s = s & 1'b0;
`endif
    if (use_s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic s, output logic [63:0] p,
                        output int lat);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    p = product;
  endtask

  task automatic run_op8(input logic [7:0] x, input logic [7:0] y,
                         input logic s, output logic [15:0] p,
                         output int lat);
    @(negedge clk);
    a8 = x; b8 = y; is_signed8 = s; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
    end
    p = product8;
  endtask

  vec_t        vecs[7];
  logic [63:0] p, p1, p2, exp;
  logic [15:0] q;
  int          lat, ndone, first, second, hold_bad;
  logic [31:0] rx, ry;
  logic        rs;

  initial begin
    vecs[0] = '{32'h7, 32'h6, 1'b0, 64'h2A, 64'h2A};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'hFFFF_FFFD, 32'h5, 1'b1,
                64'h0000_0004_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1,
                64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'h2, 1'b1,
                64'h0000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1,
                64'h3FFF_FFFF_8000_0000, 64'hC000_0000_8000_0000};
    vecs[6] = '{32'h0, 32'hDEAD_BEEF, 1'b0, 64'h0, 64'h0};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start8 = 1'b0; is_signed8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst_product", product, 64'h0);
    check("rst_ready", {63'b0, ready}, 64'h1);
    check("rst_busy", {63'b0, busy}, 64'h0);
    check("rst_done", {63'b0, done}, 64'h0);
    check("rst_product8", {48'b0, product8}, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
`ifdef MULT_SIGNED_EN
      exp = vecs[i].s ? vecs[i].exp_s : vecs[i].exp_u;
`else
      exp = vecs[i].exp_u;
`endif
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
      check($sformatf("vec%0d_product", i), p, exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_ready", i), {63'b0, ready}, 64'h1);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {63'b0, done}, 64'h0);
    end

    // start re-pulsed mid-RUN with new operands must be ignored
    @(negedge clk);
    a = 32'd7; b = 32'd6; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 5) begin
        a = 32'd9; b = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
    end
    check("midrun_done_count", 64'(ndone), 64'd1);
    check("midrun_product", product, 64'd42);

    // start held through DONE: back-to-back, Product held meanwhile
    @(negedge clk);
    a = 32'd3; b = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'd10; b = 32'd10;
    first = -1; second = -1; hold_bad = 0; p1 = '0; p2 = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (first >= 0 && i == first + 1) start = 1'b0;
      if (done) begin
        if (first < 0) begin
          first = i; p1 = product;
        end else begin
          second = i; p2 = product;
          break;
        end
      end else if (first >= 0 && product !== p1) begin
        hold_bad++;
      end
    end
    start = 1'b0;
    check("b2b_first", p1, 64'd15);
    check("b2b_second", p2, 64'd100);
    check("b2b_spacing", 64'(second - first), 64'd34);
    check("b2b_hold", 64'(hold_bad), 64'd0);

    // reset in the middle of RUN
    @(negedge clk);
    a = 32'd123; b = 32'd456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_product", product, 64'h0);
    check("midrst_ready", {63'b0, ready}, 64'h1);
    check("midrst_done", {63'b0, done}, 64'h0);
    check("midrst_busy", {63'b0, busy}, 64'h0);
    reset = 1'b0;
    run_op(32'd123, 32'd456, 1'b0, p, lat);
    check("postrst_product", p, 64'd56088);
    check("postrst_latency", 64'(lat), 64'd33);

    // reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", {63'b0, ready}, 64'h1);

    for (int i = 0; i < 25; i++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rx = 32'h8000_0000;
      if (i % 7 == 0) ry = 32'hFFFF_FFFF;
      run_op(rx, ry, rs, p, lat);
      check($sformatf("rand%0d_%h_%h_%0d", i, rx, ry, rs), p,
            ref_mul(rx, ry, rs));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
    end

    run_op8(8'hFF, 8'hFF, 1'b0, q, lat);
    check("w8_product", {48'b0, q}, 64'hFE01);
    check("w8_latency", 64'(lat), 64'd9);
    run_op8(8'hFF, 8'h02, 1'b1, q, lat);
`ifdef MULT_SIGNED_EN
    check("w8_signed_flag", {48'b0, q}, 64'hFFFE);
`else
    check("w8_signed_flag", {48'b0, q}, 64'h01FE);
`endif
    check("w8_ready", {63'b0, ready8}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
